logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
Parametrised bitwise logic unit that generalises the team's fixed 3-bit AND and OR gates. It supports WIDTH-bit operands, a 3-bit opcode selecting among eight bitwise operations, and result flags. The datapath is a 2-stage registered pipeline with valid/ready handshakes on both sides, plus a transfer counter. It sits between an operand source and any consumer that can apply backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of completed-transfer counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A
in_valid  input  1  A/B/op valid
in_ready  output  1  unit can accept this cycle
C  output  WIDTH  result
zero  output  1  C == 0
ones  output  1  C == all ones
out_valid  output  1  C/flags valid
out_ready  input  1  consumer accepts
done_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst), sampled on the rising edge.
- Reset: s1_valid=0, out_valid=0, C=0, zero=0, ones=0, done_cnt=0. in_ready=1 in the first cycle after reset is deasserted. Reset mid-flight discards both stages with no output transfer.
- Input transfer: in_valid && in_ready at a clock edge. Output transfer: out_valid && out_ready at a clock edge.
- Stage 1 registers A, B, and op on each input transfer and sets s1_valid.
- Stage 2 computes the op on the stage-1 registers, then registers C, zero, and ones. zero and ones are derived from the new C.
- Stage 2 loads when s1_valid && (!out_valid || out_ready). s1_valid clears on that load unless a new input transfer happens in the same cycle.
- out_valid sets on a stage-2 load and clears on an output transfer with no simultaneous load.
- in_ready = !s1_valid || (!out_valid || out_ready). This is combinational; there is no in_valid→in_ready path.
- Latency: an input transferred at edge N gives out_valid=1 after edge N+1 when there is no stall.
- Throughput is 1/cycle with out_ready held at 1.
- Stall: with out_ready=0 and both stages full, in_ready=0. C, zero, ones, and out_valid must hold stable until the transfer.
- Simultaneous input transfer, stage advance, and output transfer in one cycle: all three occur, with no bubble and no loss.
- Unused upper bits do not exist; every op is purely bitwise over WIDTH bits. NOT A and PASS A ignore B.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Inputs are ignored when in_valid=0; A, B, and op may be X then.

Optional Feature:
LOGIC_UNIT_PARITY_EN
- When defined, adds output port parity (1 bit), registered in stage 2 alongside C. parity = XOR reduction of C. It resets to 0 and has the same stall/hold rules as C.
- When not defined, the port and logic are absent and all other behaviour is identical.

Test Plan:
- Reset: WIDTH=3; assert rst 2 cycles mid-stream with both stages full → next cycle out_valid=0, C=3'b000, done_cnt=0, in_ready=1.
- Op sweep: WIDTH=3, A=3'b100, B=3'b110, out_ready=1; op 0..7 back-to-back → C = 100, 110, 010, 011, 001, 101, 011, 100, one per cycle from 2 cycles after the first accept; done_cnt=8.
- Flags: A=3'b000, B=3'b000, op=AND → C=000, zero=1, ones=0. A=3'b111, B=3'b111, op=OR → C=111, zero=0, ones=1.
- Backpressure: out_ready=0 and send 3 inputs → exactly 2 accepted, then in_ready=0 and C holds the first result. Release out_ready → 3 results in order, no duplicates.
- Counter wrap: CNT_W=2, 5 transfers → done_cnt sequence 1, 2, 3, 0, 1.
- Parity (macro defined): WIDTH=8, A=8'hF0, B=8'h0F, op=XOR → C=8'hFF, parity=0. A=8'h01, B=8'h00, op=OR → parity=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with result flags and a transfer counter.
// Define LOGIC_UNIT_PARITY_EN to add a registered parity output alongside C.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             ones,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] op_table(input logic [2:0] code);
        logic [3:0] tt;
        tt = 4'b0000;
        case (code)
            3'd0: tt = 4'b1000;  // AND
            3'd1: tt = 4'b1110;  // OR
            3'd2: tt = 4'b0110;  // XOR
            3'd3: tt = 4'b0111;  // NAND
            3'd4: tt = 4'b0001;  // NOR
            3'd5: tt = 4'b1001;  // XNOR
            3'd6: tt = 4'b0011;  // NOT A
            3'd7: tt = 4'b1100;  // PASS A
            default: tt = 4'b0000;
        endcase
        return tt;
    endfunction

    logic             s1_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;

    logic [WIDTH-1:0] c_reg;
    logic             zero_reg;
    logic             ones_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] done_cnt_reg;

    logic             in_xfer;
    logic             out_xfer;
    logic             s2_load;
    logic [3:0]       tt_sel;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic             ones_next;

    assign in_ready = !s1_valid_reg || !out_valid_reg || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_reg && out_ready;
    assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);

    assign tt_sel = op_table(op_reg);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign result_next[gi] = tt_sel[{a_reg[gi], b_reg[gi]}];
        end
    endgenerate

    assign zero_next = ~|result_next;
    assign ones_next = &result_next;

    // Operand registers carry no reset; s1_valid_reg qualifies them.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            c_reg         <= '0;
            zero_reg      <= 1'b0;
            ones_reg      <= 1'b0;
            done_cnt_reg  <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid_reg <= 1'b1;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                out_valid_reg <= 1'b1;
                c_reg         <= result_next;
                zero_reg      <= zero_next;
                ones_reg      <= ones_next;
            end else if (out_xfer) begin
                out_valid_reg <= 1'b0;
            end

            if (out_xfer) begin
                done_cnt_reg <= done_cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (s2_load) begin
            parity_reg <= ^result_next;
        end
    end

    assign parity = parity_reg;
`endif

    assign C         = c_reg;
    assign zero      = zero_reg;
    assign ones      = ones_reg;
    assign out_valid = out_valid_reg;
    assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed bench for logic_unit_pipe against a queue-based reference model.
module tb_logic_unit_pipe;

    localparam int W  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    op;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  C;
    logic          zero;
    logic          ones;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] done_cnt;
`ifdef LOGIC_UNIT_PARITY_EN
    logic          parity;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .zero      (zero),
        .ones      (ones),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done_cnt  (done_cnt)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int           cnt_model = 0;
    bit           acc_last  = 1'b0;
    bit           chk_rst   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] o);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // One clock: check state at negedge, drive inputs, advance the model at posedge.
    task automatic cycle(input bit r, input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] o, input bit ordy);
        bit           exp_ov;
        bit           exp_ir;
        bit           ixf;
        bit           oxf;
        logic [W-1:0] hd;
        @(negedge clk);
        // One item in flight is still in stage 1 only if it was accepted at the last edge.
        exp_ov = (exp_q.size() == 2) || (exp_q.size() == 1 && !acc_last);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("done_cnt", 32'(done_cnt), 32'(cnt_model));
        if (exp_ov) begin
            hd = exp_q[0];
            check("C", 32'(C), 32'(hd));
            check("zero", 32'(zero), 32'(hd == '0));
            check("ones", 32'(ones), 32'(&hd));
`ifdef LOGIC_UNIT_PARITY_EN
            check("parity", 32'(parity), 32'(^hd));
`endif
        end
        if (chk_rst) begin
            check("rst_C", 32'(C), 32'(0));
            check("rst_zero", 32'(zero), 32'(0));
            check("rst_ones", 32'(ones), 32'(0));
`ifdef LOGIC_UNIT_PARITY_EN
            check("rst_parity", 32'(parity), 32'(0));
`endif
            chk_rst = 1'b0;
        end
        rst       = r;
        in_valid  = iv;
        A         = a;
        B         = b;
        op        = o;
        out_ready = ordy;
        #1;
        exp_ir = (exp_q.size() < 2) || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        ixf = iv && exp_ir;
        oxf = exp_ov && ordy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            cnt_model = 0;
            acc_last  = 1'b0;
        end else begin
            if (oxf) begin
                void'(exp_q.pop_front());
                cnt_model = (cnt_model + 1) % (1 << CW);
            end
            if (ixf) exp_q.push_back(ref_op(a, b, o));
            acc_last = ixf;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        chk_rst = 1'b1;

        // Opcode sweep, back-to-back
        for (int o = 0; o < 8; o++) cycle(1'b0, 1'b1, 3'b100, 3'b110, 3'(o), 1'b1);
        idle(3);

        // Flag corners
        cycle(1'b0, 1'b1, 3'b000, 3'b000, 3'd0, 1'b1);
        cycle(1'b0, 1'b1, 3'b111, 3'b111, 3'd1, 1'b1);
        idle(3);

        // Backpressure: three offers, two accepted, then hold and release
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 3'b101, 3'b011, 3'd2, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
        idle(4);

        // Reset mid-flight with both stages full
        cycle(1'b0, 1'b1, 3'b011, 3'b110, 3'd2, 1'b0);
        cycle(1'b0, 1'b1, 3'b001, 3'b100, 3'd1, 1'b0);
        cycle(1'b1, 1'b1, 3'b111, 3'b000, 3'd0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 3'd0, 1'b0);
        chk_rst = 1'b1;
        cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++)
            cycle(1'b0, ($urandom_range(0, 9) < 7), 3'($urandom), 3'($urandom),
                  3'($urandom), ($urandom_range(0, 9) < 6));
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
